// File: rtl/sin_gen_nco_if.sv
// sin_gen_nco_if: sample request / result bundle between an NCO user and sin_gen_nco.
interface sin_gen_nco_if #(
    parameter int SW = 16,
    parameter int PW = 32
);
    logic                 en_i;
    logic [PW-1:0]        ftw_i;
    logic [PW-1:0]        poff_i;
    logic                 sync_i;
    logic                 rdy_i;
    logic signed [SW-1:0] sin_o;
    logic signed [SW-1:0] cos_o;
    logic                 val_o;
    modport master (output en_i, ftw_i, poff_i, sync_i, rdy_i, input sin_o, cos_o, val_o);
    modport slave  (input en_i, ftw_i, poff_i, sync_i, rdy_i, output sin_o, cos_o, val_o);
endinterface

// File: rtl/sin_gen_nco.sv
// sin_gen_nco: phase-accumulator NCO with 3-stage stallable sine/cosine LUT pipeline.
// Define SIN_GEN_QUARTER_WAVE_EN to keep only a quarter-wave sine table and mirror it.
module sin_gen_nco #(
    parameter int SW = 16,
    parameter int PW = 32,
    parameter int AW = 8
) (
    input logic          clk,
    input logic          rst,
    sin_gen_nco_if.slave bus_io
);
    logic [PW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        k_q;
    logic                 v1_q, v2_q, val_q;
    logic signed [SW-1:0] s2_q, c2_q, sin_q, cos_q;
    logic signed [SW-1:0] lut_s, lut_c;
    logic                 stall;

    function automatic logic signed [SW-1:0] lut_val(input int idx, input logic is_cos);
        real a, x;
        a = 2.0 * 3.14159265358979323846 * real'(idx) / real'(2 ** AW);
        x = (is_cos ? $cos(a) : $sin(a)) * (2.0 ** (SW - 1) - 1.0);
        return SW'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
    endfunction

`ifdef SIN_GEN_QUARTER_WAVE_EN
    localparam int Q  = 2 ** (AW - 2);
    localparam int QW = AW - 1;
    logic signed [SW-1:0] q_lut [Q + 1];
    logic [AW-2:0]        rz, rm;
    logic signed [SW-1:0] s_mag, c_mag;
    for (genvar i = 0; i <= Q; i++) begin : g_qlut
        assign q_lut[i] = lut_val(i, 1'b0);
    end
    // cos(k) is sin(k + quarter): quadrant bit 0 swaps mirror direction, xor of both bits flips sign
    always_comb begin
        rz    = {1'b0, k_q[AW-3:0]};
        rm    = QW'(Q) - rz;
        s_mag = k_q[AW-2] ? q_lut[rm] : q_lut[rz];
        c_mag = k_q[AW-2] ? q_lut[rz] : q_lut[rm];
        lut_s = k_q[AW-1] ? -s_mag : s_mag;
        lut_c = (k_q[AW-1] ^ k_q[AW-2]) ? -c_mag : c_mag;
    end
`else
    logic signed [SW-1:0] sin_lut [2 ** AW];
    logic signed [SW-1:0] cos_lut [2 ** AW];
    for (genvar i = 0; i < 2 ** AW; i++) begin : g_lut
        assign sin_lut[i] = lut_val(i, 1'b0);
        assign cos_lut[i] = lut_val(i, 1'b1);
    end
    assign lut_s = sin_lut[k_q];
    assign lut_c = cos_lut[k_q];
`endif

    assign stall = val_q && !bus_io.rdy_i;

    always_comb begin
        acc_d = stall ? acc_q : bus_io.sync_i ? '0 : bus_io.en_i ? acc_q + bus_io.ftw_i : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            k_q   <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s2_q  <= '0;
            c2_q  <= '0;
            val_q <= 1'b0;
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (!stall) begin
                v1_q  <= bus_io.en_i;
                k_q   <= AW'((acc_q + bus_io.poff_i) >> (PW - AW));
                v2_q  <= v1_q;
                s2_q  <= lut_s;
                c2_q  <= lut_c;
                val_q <= v2_q;
                if (v2_q) begin
                    sin_q <= s2_q;
                    cos_q <= c2_q;
                end
            end
        end
    end

    assign bus_io.sin_o = sin_q;
    assign bus_io.cos_o = cos_q;
    assign bus_io.val_o = val_q;
endmodule

// File: tb/tb_sin_gen_nco.sv
// tb_sin_gen_nco: scoreboard bench for sin_gen_nco; driver queues expected samples, monitor compares.
module tb_sin_gen_nco;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sin_gen_nco_if #(.SW(16), .PW(32)) bus ();
    sin_gen_nco #(.SW(16), .PW(32), .AW(8)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    typedef struct {
        logic [7:0]        k;
        logic signed [15:0] s;
        logic signed [15:0] c;
    } exp_t;

    exp_t               sbq[$];
    exp_t               mon_e;
    int                 checks = 0;
    int                 failures = 0;
    logic [31:0]        acc_m = '0;
    logic               prev_stall = 1'b0;
    logic signed [15:0] hs, hc;
    logic [10:0]        en_pat, exp_v, vv;
    logic signed [15:0] sv [11];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    endfunction

    function automatic void model(input logic [7:0] k, output logic signed [15:0] s, output logic signed [15:0] c);
        real a;
        if (k[5:0] == 6'd0) begin
            s = k[7:6] == 2'd1 ? 16'sd32767 : k[7:6] == 2'd3 ? -16'sd32767 : 16'sd0;
            c = k[7:6] == 2'd0 ? 16'sd32767 : k[7:6] == 2'd2 ? -16'sd32767 : 16'sd0;
        end else begin
            a = 2.0 * 3.14159265358979323846 * real'(k) / 256.0;
            s = 16'(rnd($sin(a) * 32767.0));
            c = 16'(rnd($cos(a) * 32767.0));
        end
    endfunction

    // called #1 after a rising edge; returns #1 after the next one
    task automatic drive(input logic en, input logic sy, input logic rd);
        logic        iss;
        logic [31:0] p;
        exp_t        e;
        bus.en_i   = en;
        bus.sync_i = sy;
        bus.rdy_i  = rd;
        iss = !(bus.val_o && !rd);
        if (iss && en) begin
            p   = acc_m + bus.poff_i;
            e.k = p[31:24];
            model(e.k, e.s, e.c);
            sbq.push_back(e);
        end
        if (iss) acc_m = sy ? 32'd0 : en ? acc_m + bus.ftw_i : acc_m;
        @(posedge clk);
        #1;
    endtask

    task automatic lat3(input string name);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            chk($sformatf("%s_val_edge%0d", name, i + 1), bus.val_o, i == 2);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_sin", bus.sin_o, hs);
                chk("stall_hold_cos", bus.cos_o, hc);
                chk("stall_hold_val", bus.val_o, 1);
            end
            prev_stall = bus.val_o && !bus.rdy_i;
            hs = bus.sin_o;
            hc = bus.cos_o;
            if (bus.val_o && bus.rdy_i) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample: got sin=%0d cos=%0d with nothing outstanding", bus.sin_o, bus.cos_o);
                end else begin
                    mon_e = sbq.pop_front();
                    chk($sformatf("sin_k%0d", mon_e.k), bus.sin_o, mon_e.s);
                    chk($sformatf("cos_k%0d", mon_e.k), bus.cos_o, mon_e.c);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.en_i    = 1'b0;
        bus.sync_i  = 1'b0;
        bus.rdy_i   = 1'b1;
        bus.ftw_i   = '0;
        bus.poff_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_val", bus.val_o, 0);
        chk("reset_sin", bus.sin_o, 0);
        chk("reset_cos", bus.cos_o, 0);
        rst = 1'b0;

        // full LUT sweep, one sample per index
        bus.ftw_i = 32'h0100_0000;
        lat3("lat");
        repeat (260) drive(1'b1, 1'b0, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 1'b1);
        chk("drain_sweep", sbq.size(), 0);

        // quarter-turn steps from a synced accumulator
        bus.ftw_i = 32'h4000_0000;
        drive(1'b0, 1'b1, 1'b1);
        repeat (8) drive(1'b1, 1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b1);
        chk("drain_quarter", sbq.size(), 0);

        // constant phase from offset, then sync mid-stream
        bus.ftw_i  = '0;
        bus.poff_i = 32'h4000_0000;
        repeat (6) drive(1'b1, 1'b0, 1'b1);
        bus.ftw_i  = 32'h4000_0000;
        bus.poff_i = '0;
        repeat (2) drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b1);
        chk("drain_sync", sbq.size(), 0);

        // random backpressure including a 5-cycle stall
        bus.ftw_i = 32'h0100_0000;
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        repeat (10) drive(1'b0, 1'b0, 1'b1);
        chk("drain_stall", sbq.size(), 0);

        // single bubble travels through the pipeline
        en_pat = 11'b00001110111;
        exp_v  = 11'b00111011100;
        for (int i = 0; i < 11; i++) begin
            drive(en_pat[i], 1'b0, 1'b1);
            vv[i] = bus.val_o;
            sv[i] = bus.sin_o;
        end
        chk("bubble_pattern", vv, exp_v);
        chk("bubble_hold_sin", sv[5], sv[4]);
        chk("drain_bubble", sbq.size(), 0);

        // asynchronous reset mid-stream, then restart with an offset
        repeat (5) drive(1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_val", bus.val_o, 0);
        chk("async_rst_sin", bus.sin_o, 0);
        chk("async_rst_cos", bus.cos_o, 0);
        sbq.delete();
        acc_m = '0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.poff_i = 32'h4000_0000;
        lat3("rst_lat");
        repeat (4) drive(1'b1, 1'b0, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 1'b1);
        chk("drain_final", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sin_gen_nco.md
SIN_GEN_NCO -- requirements
Module: sin_gen_nco

Interface
REQ-001 SHALL have parameter SW, default 16, signed output sample width.
REQ-002 SHALL have parameter PW, default 32, phase accumulator width.
REQ-003 SHALL have parameter AW, default 8, LUT phase address bits (2^AW points per cycle); AW>=3, AW<=PW.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en_i  input  1  request a new sample into the pipeline each unstalled cycle.
REQ-007 SHALL have port ftw_i  input  PW  frequency tuning word, unsigned phase increment.
REQ-008 SHALL have port poff_i  input  PW  phase offset added to accumulator before lookup.
REQ-009 SHALL have port sync_i  input  1  clear phase accumulator to zero.
REQ-010 SHALL have port rdy_i  input  1  downstream ready.
REQ-011 SHALL have port sin_o  output  SW  signed sine sample.
REQ-012 SHALL have port cos_o  output  SW  signed cosine sample.
REQ-013 SHALL have port val_o  output  1  sin_o/cos_o valid.

Function
REQ-014 SHALL define stall = val_o && !rdy_i; on stall, the accumulator, all pipeline stages, and the outputs hold.
REQ-015 SHALL, when not stalled and en_i=1, issue sample phase p = (acc + poff_i) mod 2^PW and update acc <= (acc + ftw_i) mod 2^PW.
REQ-016 SHALL ignore ftw_i and poff_i and hold acc when en_i=0 or stalled.
REQ-017 SHALL, on sync_i=1 when not stalled, set acc to 0 with priority over the increment; the sample issued that cycle uses the pre-sync acc; the next issued sample uses phase poff_i.
REQ-018 SHALL ignore sync_i while stalled.
REQ-019 SHALL use LUT index k = p[PW-1 -: AW] (truncation, no rounding or dither).
REQ-020 SHALL output sin_o = round(sin(2*pi*k/2^AW) * (2^(SW-1)-1)) and cos_o = the same with cos, two's complement, rounding half away from zero; full-scale is +/-(2^(SW-1)-1), never -2^(SW-1).
REQ-021 SHALL have a 3-stage pipeline (phase register, LUT read, output register), each stage with its own valid bit; an issued sample appears on the outputs with val_o=1 exactly 3 unstalled cycles after issue.
REQ-022 SHALL let bubbles (en_i=0) propagate as val_o=0; sin_o and cos_o hold their last valid value while val_o=0.
REQ-023 SHALL neither drop nor duplicate samples across any stall pattern; a sample is consumed only on a cycle with val_o && rdy_i.
REQ-024 SHALL wrap acc and p modulo 2^PW silently, with no flag.
REQ-025 SHALL build the LUT at elaboration from real-valued math; no external memory files.

Reset
REQ-026 SHALL, on rst=1, asynchronously clear acc, all stage valids, and val_o to 0, and set sin_o=0 and cos_o=0.
REQ-027 SHALL discard in-flight samples on reset mid-operation; after rst deasserts with en_i=1, the first val_o=1 occurs 3 cycles later with phase poff_i.

Configuration
REQ-028 SHALL, with macro SIN_GEN_QUARTER_WAVE_EN defined, store only 2^(AW-2)+1 sine entries (0..pi/2 inclusive) and derive both outputs by quadrant mirroring and negation.
REQ-029 SHALL, without SIN_GEN_QUARTER_WAVE_EN, store full 2^AW-entry sine and cosine tables.
REQ-030 SHALL produce bit-identical sin_o/cos_o/val_o streams and identical latency in both builds.

Verification (defaults SW=16, PW=32, AW=8)
REQ-031 SHALL cover: ftw_i=2^24, poff_i=0, en_i=rdy_i=1 after reset -> first val_o 3 cycles after en_i; samples 0 and 64 are (sin,cos)=(0,32767) and (32767,0); sample k matches the REQ-020 formula for all k in 0..255; run with and without SIN_GEN_QUARTER_WAVE_EN, streams identical.
REQ-032 SHALL cover: ftw_i=2^30, poff_i=0 -> repeating (0,32767),(32767,0),(0,-32767),(-32767,0).
REQ-033 SHALL cover: ftw_i=0, poff_i=2^30 -> constant (32767,0); then sync_i pulse mid-stream with ftw_i=2^30, poff_i=0 -> sample issued after sync is (0,32767).
REQ-034 SHALL cover: random rdy_i (including rdy_i=0 for 5 cycles) with ftw_i=2^24 -> accepted samples form an unbroken index sequence with no gaps or repeats, and outputs are stable during stall.
REQ-035 SHALL cover: en_i toggled 1-0-1 -> exactly one val_o=0 bubble, 3 cycles later, with index continuity preserved.
REQ-036 SHALL cover: rst asserted asynchronously mid-stream -> val_o=0 and sin_o=cos_o=0 before the next clk edge; restart per REQ-027.
